// File: rtl/cv32e40p_rf_banked_pkg.sv
// Shared types, caller-save index tables and size helpers for the banked register file.
package cv32e40p_rf_banked_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SAVE,
        SEQ_RESTORE,
        SEQ_ACK
    } rf_seq_state_e;

    localparam int unsigned BEAT_W    = 5;
    localparam int unsigned CS_STD_N  = 16;
    localparam int unsigned CS_EABI_N = 7;

    localparam logic [4:0] CS_STD [CS_STD_N] = '{
        5'd1,  5'd5,  5'd6,  5'd7,  5'd10, 5'd11, 5'd12, 5'd13,
        5'd14, 5'd15, 5'd16, 5'd17, 5'd28, 5'd29, 5'd30, 5'd31
    };

    localparam logic [4:0] CS_EABI [CS_EABI_N] = '{
        5'd1, 5'd5, 5'd10, 5'd11, 5'd12, 5'd13, 5'd15
    };

    function automatic int unsigned nregs(input bit eabi);
        return eabi ? CS_EABI_N : CS_STD_N;
    endfunction

    // Architectural register number of caller-save slot pos; 0 for slots past the set.
    function automatic logic [4:0] cs_reg(input bit eabi, input int unsigned pos);
        logic [4:0] r;
        r = '0;
        if (eabi) begin
            if (pos < CS_EABI_N) r = CS_EABI[pos[2:0]];
        end else begin
            if (pos < CS_STD_N) r = CS_STD[pos[3:0]];
        end
        return r;
    endfunction

endpackage

// File: rtl/cv32e40p_rf_shadow_seq.sv
// Save/restore sequencer: request arbitration, beat and depth counting, ack/err pulses.
module cv32e40p_rf_shadow_seq
    import cv32e40p_rf_banked_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned BEATS     = 4,
    parameter int unsigned DEPTH_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               save_req_i,
    input  logic               restore_req_i,
    output logic               save_ack_o,
    output logic               restore_ack_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               copy_en_o,
    output logic               copy_restore_o,
    output logic [BEAT_W-1:0]  beat_o,
    output logic               last_beat_o,
    output rf_seq_state_e      state_o
);

    // Handshake: a request is a level held by the core until the matching ack pulse;
    // it is only sampled in IDLE, and the ACK cycle always returns to IDLE first.
    rf_seq_state_e      state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic               op_restore_q, op_restore_d;
    logic               last_beat;

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        depth_d      = depth_q;
        err_d        = err_q;
        op_restore_d = op_restore_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (save_req_i) begin
                    op_restore_d = 1'b0;
                    beat_d       = '0;
                    if (depth_q == DEPTH_W'(NUM_BANKS)) begin
                        err_d   = 1'b1;
                        state_d = SEQ_ACK;
                    end else begin
                        err_d   = 1'b0;
                        state_d = SEQ_SAVE;
                    end
                end else if (restore_req_i) begin
                    op_restore_d = 1'b1;
                    beat_d       = '0;
                    if (depth_q == '0) begin
                        err_d   = 1'b1;
                        state_d = SEQ_ACK;
                    end else begin
                        err_d   = 1'b0;
                        state_d = SEQ_RESTORE;
                    end
                end
            end
            SEQ_SAVE: begin
                if (last_beat) begin
                    depth_d = depth_q + 1'b1;
                    state_d = SEQ_ACK;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            SEQ_RESTORE: begin
                if (last_beat) begin
                    depth_d = depth_q - 1'b1;
                    state_d = SEQ_ACK;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            SEQ_ACK: begin
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEQ_IDLE;
            beat_q       <= '0;
            depth_q      <= '0;
            err_q        <= 1'b0;
            op_restore_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            depth_q      <= depth_d;
            err_q        <= err_d;
            op_restore_q <= op_restore_d;
        end
    end

    assign save_ack_o     = (state_q == SEQ_ACK) && !op_restore_q;
    assign restore_ack_o  = (state_q == SEQ_ACK) && op_restore_q;
    assign err_o          = (state_q == SEQ_ACK) && err_q;
    assign busy_o         = (state_q != SEQ_IDLE);
    assign depth_o        = depth_q;
    assign copy_en_o      = (state_q == SEQ_SAVE) || (state_q == SEQ_RESTORE);
    assign copy_restore_o = (state_q == SEQ_RESTORE);
    assign beat_o         = beat_q;
    assign last_beat_o    = last_beat;
    assign state_o        = state_q;

endmodule

// File: rtl/cv32e40p_register_file_banked.sv
// Flip-flop integer register file with nested shadow banks for fast-interrupt save/restore.
module cv32e40p_register_file_banked
    import cv32e40p_rf_banked_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned ABI_EABI   = 0,
    parameter int unsigned SAVE_RATE  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          raddr_a_i,
    output logic [DATA_WIDTH-1:0]          rdata_a_o,
    input  logic [ADDR_WIDTH-1:0]          raddr_b_i,
    output logic [DATA_WIDTH-1:0]          rdata_b_o,
    input  logic [ADDR_WIDTH-1:0]          raddr_c_i,
    output logic [DATA_WIDTH-1:0]          rdata_c_o,
    input  logic [ADDR_WIDTH-1:0]          waddr_a_i,
    input  logic [DATA_WIDTH-1:0]          wdata_a_i,
    input  logic                           we_a_i,
    input  logic [ADDR_WIDTH-1:0]          waddr_b_i,
    input  logic [DATA_WIDTH-1:0]          wdata_b_i,
    input  logic                           we_b_i,
    input  logic                           save_req_i,
    input  logic                           restore_req_i,
    output logic                           save_ack_o,
    output logic                           restore_ack_o,
    output logic                           busy_o,
    output logic                           err_o,
    output logic [$clog2(NUM_BANKS+1)-1:0] depth_o,
    input  logic [3:0]                     shadow_raddr_i,
    output logic [DATA_WIDTH-1:0]          shadow_rdata_o
);

    localparam bit          EABI      = (ABI_EABI != 0);
    localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int unsigned NREGS     = nregs(EABI);
    localparam int unsigned BEATS     = (NREGS + SAVE_RATE - 1) / SAVE_RATE;
    localparam int unsigned DEPTH_W   = $clog2(NUM_BANKS + 1);
    localparam logic [DATA_WIDTH-1:0] SP_ADJ = DATA_WIDTH'(NREGS * 4);
    localparam logic [ADDR_WIDTH-1:0] SP_IDX = ADDR_WIDTH'(2);

    if (!(SAVE_RATE == 1 || SAVE_RATE == 2 || SAVE_RATE == 4 ||
          SAVE_RATE == 8 || SAVE_RATE == 16)) begin : g_bad_save_rate
        $fatal(1, "SAVE_RATE must be 1, 2, 4, 8 or 16");
    end
    if (NUM_BANKS < 1 || NUM_BANKS > 8) begin : g_bad_num_banks
        $fatal(1, "NUM_BANKS must be in 1..8");
    end

    logic [DATA_WIDTH-1:0] mem_q  [NUM_WORDS];
    logic [DATA_WIDTH-1:0] mem_d  [NUM_WORDS];
    logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS][NREGS];
    logic [DATA_WIDTH-1:0] bank_d [NUM_BANKS][NREGS];

    logic               copy_en;
    logic               copy_restore;
    logic [BEAT_W-1:0]  beat;
    logic               last_beat;
    rf_seq_state_e      seq_state;

    cv32e40p_rf_shadow_seq #(
        .NUM_BANKS (NUM_BANKS),
        .BEATS     (BEATS),
        .DEPTH_W   (DEPTH_W)
    ) u_seq (
        .clk            (clk),
        .rst            (rst),
        .save_req_i     (save_req_i),
        .restore_req_i  (restore_req_i),
        .save_ack_o     (save_ack_o),
        .restore_ack_o  (restore_ack_o),
        .busy_o         (busy_o),
        .err_o          (err_o),
        .depth_o        (depth_o),
        .copy_en_o      (copy_en),
        .copy_restore_o (copy_restore),
        .beat_o         (beat),
        .last_beat_o    (last_beat),
        .state_o        (seq_state)
    );

    // Save copies into bank[depth]; restore reads bank[depth-1]. Core writes are applied last.
    always_comb begin
        mem_d  = mem_q;
        bank_d = bank_q;
        if (copy_en) begin
            for (int p = 0; p < NREGS; p++) begin
                if (BEAT_W'(p / SAVE_RATE) == beat) begin
                    for (int b = 0; b < NUM_BANKS; b++) begin
                        if (!copy_restore && depth_o == DEPTH_W'(b))
                            bank_d[b][p] = mem_q[ADDR_WIDTH'(cs_reg(EABI, p))];
                        if (copy_restore && depth_o == DEPTH_W'(b + 1))
                            mem_d[ADDR_WIDTH'(cs_reg(EABI, p))] = bank_q[b][p];
                    end
                end
            end
            if (last_beat)
                mem_d[SP_IDX] = copy_restore ? mem_q[SP_IDX] + SP_ADJ : mem_q[SP_IDX] - SP_ADJ;
        end
        if (we_a_i && waddr_a_i != '0) mem_d[waddr_a_i] = wdata_a_i;
        if (we_b_i && waddr_b_i != '0) mem_d[waddr_b_i] = wdata_b_i;
        mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
            for (int b = 0; b < NUM_BANKS; b++)
                for (int p = 0; p < NREGS; p++) bank_q[b][p] <= '0;
        end else begin
            mem_q  <= mem_d;
            bank_q <= bank_d;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
    assign rdata_c_o = mem_q[raddr_c_i];

    always_comb begin
        shadow_rdata_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (depth_o == DEPTH_W'(b + 1)) begin
                for (int p = 0; p < NREGS; p++) begin
                    if (shadow_raddr_i == 4'(p)) shadow_rdata_o = bank_q[b][p];
                end
            end
        end
    end

    a_no_write_while_busy : assert property (@(posedge clk) disable iff (rst)
        !((seq_state != SEQ_IDLE) && (we_a_i || we_b_i)))
        else $error("register write issued while save/restore sequencer is busy");

endmodule

// File: tb/tb_cv32e40p_register_file_banked.sv
// Directed bench for the banked register file: standard ABI x4 rate and EABI x1 rate.
module tb_cv32e40p_register_file_banked;

    logic        clk;
    logic        rst;
    logic [4:0]  raddr_a, raddr_b, raddr_c, waddr_a, waddr_b;
    logic [31:0] rdata_a, rdata_b, rdata_c, wdata_a, wdata_b;
    logic        we_a, we_b, save_req, restore_req;
    logic        save_ack, restore_ack, busy, err;
    logic [1:0]  depth;
    logic [3:0]  shadow_raddr;
    logic [31:0] shadow_rdata;

    logic [4:0]  e_raddr_a, e_waddr_a;
    logic [31:0] e_rdata_a, e_rdata_b, e_rdata_c, e_wdata_a;
    logic        e_we_a, e_save_req, e_save_ack, e_restore_ack, e_busy, e_err;
    logic [1:0]  e_depth;
    logic [3:0]  e_shadow_raddr;
    logic [31:0] e_shadow_rdata;

    int tests_run = 0;
    int fails     = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  cs_std [16] = '{5'd1, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd12, 5'd13,
                                 5'd14, 5'd15, 5'd16, 5'd17, 5'd28, 5'd29, 5'd30, 5'd31};

    cv32e40p_register_file_banked #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_BANKS(2), .ABI_EABI(0), .SAVE_RATE(4)
    ) dut (
        .clk(clk), .rst(rst),
        .raddr_a_i(raddr_a), .rdata_a_o(rdata_a),
        .raddr_b_i(raddr_b), .rdata_b_o(rdata_b),
        .raddr_c_i(raddr_c), .rdata_c_o(rdata_c),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .save_req_i(save_req), .restore_req_i(restore_req),
        .save_ack_o(save_ack), .restore_ack_o(restore_ack),
        .busy_o(busy), .err_o(err), .depth_o(depth),
        .shadow_raddr_i(shadow_raddr), .shadow_rdata_o(shadow_rdata)
    );

    cv32e40p_register_file_banked #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_BANKS(2), .ABI_EABI(1), .SAVE_RATE(1)
    ) dut_e (
        .clk(clk), .rst(rst),
        .raddr_a_i(e_raddr_a), .rdata_a_o(e_rdata_a),
        .raddr_b_i(5'd0), .rdata_b_o(e_rdata_b),
        .raddr_c_i(5'd0), .rdata_c_o(e_rdata_c),
        .waddr_a_i(e_waddr_a), .wdata_a_i(e_wdata_a), .we_a_i(e_we_a),
        .waddr_b_i(5'd0), .wdata_b_i(32'd0), .we_b_i(1'b0),
        .save_req_i(e_save_req), .restore_req_i(1'b0),
        .save_ack_o(e_save_ack), .restore_ack_o(e_restore_ack),
        .busy_o(e_busy), .err_o(e_err), .depth_o(e_depth),
        .shadow_raddr_i(e_shadow_raddr), .shadow_rdata_o(e_shadow_rdata)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Driver tasks: all start and end at a falling edge.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        waddr_a = a; wdata_a = d; we_a = 1'b1;
        @(negedge clk);
        we_a = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        raddr_a = a;
        #1 d = rdata_a;
        @(negedge clk);
    endtask

    task automatic rd_shadow(input logic [3:0] a, output logic [31:0] d);
        shadow_raddr = a;
        #1 d = shadow_rdata;
        @(negedge clk);
    endtask

    task automatic wait_ack(input bit is_restore, output int lat, output logic e);
        lat = 0;
        e   = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (is_restore ? restore_ack : save_ack) begin
                lat = i;
                e   = err;
                break;
            end
        end
    endtask

    task automatic run_op(input bit is_restore, output int lat, output logic e);
        if (is_restore) restore_req = 1'b1;
        else save_req = 1'b1;
        wait_ack(is_restore, lat, e);
        save_req    = 1'b0;
        restore_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic e_write(input logic [4:0] a, input logic [31:0] d);
        e_waddr_a = a; e_wdata_a = d; e_we_a = 1'b1;
        @(negedge clk);
        e_we_a = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [31:0] d;
        logic [31:0] v;

        rst = 1'b1;
        raddr_a = '0; raddr_b = '0; raddr_c = '0;
        waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0;
        we_a = 1'b0; we_b = 1'b0; save_req = 1'b0; restore_req = 1'b0;
        shadow_raddr = '0;
        e_raddr_a = '0; e_waddr_a = '0; e_wdata_a = '0; e_we_a = 1'b0;
        e_save_req = 1'b0; e_shadow_raddr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_save_ack", 32'(save_ack), 32'd0);
        check("rst_restore_ack", 32'(restore_ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_shadow", shadow_rdata, 32'd0);
        rd(5'd2, d);
        check("rst_sp", d, 32'd0);

        // Write ports: b beats a on the same address, x0 stays 0, two addresses at once
        waddr_a = 5'd3; wdata_a = 32'h0000_1111; we_a = 1'b1;
        waddr_b = 5'd3; wdata_b = 32'h0000_2222; we_b = 1'b1;
        @(negedge clk);
        waddr_a = 5'd4; wdata_a = 32'h0000_0044;
        waddr_b = 5'd8; wdata_b = 32'h0000_0088;
        @(negedge clk);
        waddr_a = 5'd0; wdata_a = 32'hFFFF_FFFF; we_b = 1'b0;
        @(negedge clk);
        we_a = 1'b0;
        raddr_b = 5'd4; raddr_c = 5'd8;
        #1;
        check("wr_port_b_prio", dut.rdata_a_o, 32'h0);
        check("rd_port_b", rdata_b, 32'h0000_0044);
        check("rd_port_c", rdata_c, 32'h0000_0088);
        @(negedge clk);
        rd(5'd3, d);
        check("wr_b_wins", d, 32'h0000_2222);
        rd(5'd0, d);
        check("wr_x0_ignored", d, 32'd0);

        // Test 1: fill the caller-save set, save
        for (int i = 0; i < 16; i++) begin
            v = (cs_std[i] == 5'd10) ? 32'hA5A5_0001 : (32'h0100_0000 | 32'(cs_std[i]));
            write_reg(cs_std[i], v);
            exp_q.push_back(v);
        end
        write_reg(5'd2, 32'h0000_1000);
        run_op(1'b0, lat, e);
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_err", 32'(e), 32'd0);
        check("t1_depth", 32'(depth), 32'd1);
        rd(5'd2, d);
        check("t1_sp", d, 32'h0000_0FC0);
        rd_shadow(4'd4, d);
        check("t1_shadow4", d, 32'hA5A5_0001);
        for (int i = 0; i < 16; i++) begin
            rd_shadow(4'(i), d);
            check($sformatf("t1_shadow_%0d", i), d, exp_q.pop_front());
        end

        // Test 2: clobber and restore
        write_reg(5'd10, 32'd0);
        write_reg(5'd31, 32'd0);
        run_op(1'b1, lat, e);
        check("t2_latency", 32'(lat), 32'd5);
        check("t2_err", 32'(e), 32'd0);
        check("t2_depth", 32'(depth), 32'd0);
        rd(5'd10, d);
        check("t2_x10", d, 32'hA5A5_0001);
        rd(5'd31, d);
        check("t2_x31", d, 32'h0100_001F);
        rd(5'd2, d);
        check("t2_sp", d, 32'h0000_1000);
        rd_shadow(4'd4, d);
        check("t2_shadow_empty", d, 32'd0);

        // Test 3: overflow on the third save
        run_op(1'b0, lat, e);
        check("t3_s1_err", 32'(e), 32'd0);
        run_op(1'b0, lat, e);
        check("t3_s2_latency", 32'(lat), 32'd5);
        check("t3_s2_depth", 32'(depth), 32'd2);
        run_op(1'b0, lat, e);
        check("t3_s3_latency", 32'(lat), 32'd1);
        check("t3_s3_err", 32'(e), 32'd1);
        check("t3_depth", 32'(depth), 32'd2);
        rd(5'd2, d);
        check("t3_sp", d, 32'h0000_0F80);

        // Test 4: underflow
        run_op(1'b1, lat, e);
        run_op(1'b1, lat, e);
        check("t4_depth0", 32'(depth), 32'd0);
        run_op(1'b1, lat, e);
        check("t4_latency", 32'(lat), 32'd1);
        check("t4_err", 32'(e), 32'd1);
        check("t4_depth", 32'(depth), 32'd0);
        rd(5'd2, d);
        check("t4_sp", d, 32'h0000_1000);
        rd(5'd10, d);
        check("t4_x10", d, 32'hA5A5_0001);

        // Test 5: simultaneous requests at depth 1
        run_op(1'b0, lat, e);
        save_req = 1'b1; restore_req = 1'b1;
        wait_ack(1'b0, lat, e);
        check("t5_save_latency", 32'(lat), 32'd5);
        check("t5_save_depth", 32'(depth), 32'd2);
        save_req = 1'b0;
        wait_ack(1'b1, lat, e);
        restore_req = 1'b0;
        check("t5_restore_seen", 32'(lat != 0), 32'd1);
        check("t5_restore_err", 32'(e), 32'd0);
        check("t5_depth", 32'(depth), 32'd1);
        @(negedge clk);
        rd(5'd2, d);
        check("t5_sp", d, 32'h0000_0FC0);

        // Test 6: reset during SAVE beat 2
        save_req = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1; save_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("t6_no_ack", 32'(save_ack), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_depth", 32'(depth), 32'd0);
        rd(5'd2, d);
        check("t6_sp", d, 32'd0);

        // EABI, one register per cycle
        e_write(5'd2, 32'h0000_0100);
        e_write(5'd15, 32'h1234_5678);
        e_save_req = 1'b1;
        lat = 0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (e_save_ack) begin
                lat = i;
                e   = e_err;
                break;
            end
        end
        e_save_req = 1'b0;
        @(negedge clk);
        check("e_latency", 32'(lat), 32'd8);
        check("e_err", 32'(e), 32'd0);
        check("e_depth", 32'(e_depth), 32'd1);
        e_raddr_a = 5'd2; e_shadow_raddr = 4'd6;
        #1;
        check("e_sp", e_rdata_a, 32'h0000_00E4);
        check("e_shadow6", e_shadow_rdata, 32'h1234_5678);
        e_shadow_raddr = 4'd7;
        #1;
        check("e_shadow_oob", e_shadow_rdata, 32'd0);
        check("e_restore_ack_idle", 32'(e_restore_ack), 32'd0);
        check("e_busy_idle", 32'(e_busy), 32'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
